// File: rtl/msk_skinny_driver.sv
// Purpose: host-side share/unshare driver for the d-share masked SKINNY core.
// Latency: accept -> core_start 1 cycle; core_done -> out_valid 1 cycle; minimum accept -> out_valid 3 cycles.
// Backpressure: one block in flight; in_ready low from accept until the result handshake or a watchdog abort.
//
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   in_valid/in_ready/in_data     unmasked input block handshake
//   rnd_mask                      (d-1)*W bits of fresh randomness, used on the input handshake
//   core_start/core_pt            one-cycle start pulse and bit-interleaved masked block to the core
//   core_done/core_ct             core completion and bit-interleaved masked result
//   out_valid/out_ready/out_data  unmasked result handshake
//   err_timeout                   sticky watchdog flag, cleared only by reset
//   blk_cnt                       completed-block counter, wraps at 16 bits
module msk_skinny_driver #(
    parameter int d       = 2,
    parameter int W       = 128,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic [(d-1)*W-1:0] rnd_mask,
    output logic               core_start,
    output logic [W*d-1:0]     core_pt,
    input  logic               core_done,
    input  logic [W*d-1:0]     core_ct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic               err_timeout,
    output logic [15:0]        blk_cnt
);

    // Counter must hold TIMEOUT itself, so size for TIMEOUT+1 distinct values plus headroom.
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cyc_cnt;

    logic [W-1:0]    rnd_xor;
    logic [W*d-1:0]  pt_next;
    logic [W-1:0]    ct_xor;

    // Share split. The unmasked block only ever feeds the last share through
    // this XOR, so no register ever holds in_data in the clear.
    always_comb begin
        rnd_xor = '0;
        for (int j = 0; j < d - 1; j++) begin
            rnd_xor = rnd_xor ^ rnd_mask[W*j +: W];
        end
        pt_next = '0;
        for (int o = 0; o < W; o++) begin
            for (int j = 0; j < d - 1; j++) begin
                pt_next[d*o + j] = rnd_mask[W*j + o];
            end
            pt_next[d*o + d - 1] = in_data[o] ^ rnd_xor[o];
        end
    end

    // Recombination: each output bit is the XOR of its d adjacent share bits.
    always_comb begin
        ct_xor = '0;
        for (int o = 0; o < W; o++) begin
            ct_xor[o] = ^core_ct[d*o +: d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            core_start  <= 1'b0;
            core_pt     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            err_timeout <= 1'b0;
            blk_cnt     <= '0;
            cyc_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // core_pt only changes here, so it stays frozen through START and BUSY.
                    if (in_valid && in_ready) begin
                        core_pt    <= pt_next;
                        core_start <= 1'b1;
                        in_ready   <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    core_start <= 1'b0;
                    cyc_cnt    <= '0;
                    state      <= BUSY;
                end
                BUSY: begin
                    // done takes priority over the watchdog on the same edge.
                    if (core_done) begin
                        out_data  <= ct_xor;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if (cyc_cnt == TMAX) begin
                        err_timeout <= 1'b1;
                        in_ready    <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        blk_cnt   <= blk_cnt + 16'd1;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msk_skinny_driver.sv
module tb_msk_skinny_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A: d=2, W=128, short watchdog for the directed tests.
    logic         a_in_valid, a_in_ready, a_core_start, a_core_done;
    logic         a_out_valid, a_out_ready, a_err;
    logic [127:0] a_in_data, a_rnd, a_out_data;
    logic [255:0] a_core_pt, a_core_ct;
    logic [15:0]  a_blk;

    // Instance B: d=3, W=128, random loopback traffic.
    logic         b_in_valid, b_in_ready, b_core_start, b_core_done;
    logic         b_out_valid, b_out_ready, b_err;
    logic [127:0] b_in_data, b_out_data;
    logic [255:0] b_rnd;
    logic [383:0] b_core_pt, b_core_ct;
    logic [15:0]  b_blk;

    msk_skinny_driver #(.d(2), .W(128), .TIMEOUT(15)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .rnd_mask(a_rnd), .core_start(a_core_start), .core_pt(a_core_pt),
        .core_done(a_core_done), .core_ct(a_core_ct),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .err_timeout(a_err), .blk_cnt(a_blk)
    );

    msk_skinny_driver #(.d(3), .W(128), .TIMEOUT(15)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .rnd_mask(b_rnd), .core_start(b_core_start), .core_pt(b_core_pt),
        .core_done(b_core_done), .core_ct(b_core_ct),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .err_timeout(b_err), .blk_cnt(b_blk)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two-share split: share0 = rnd, share1 = data ^ rnd, share j of bit o at 2*o+j.
    function automatic logic [255:0] pt2(input logic [127:0] din, input logic [127:0] rnd);
        logic [255:0] p;
        for (int o = 0; o < 128; o++) begin
            p[2*o]     = rnd[o];
            p[2*o + 1] = din[o] ^ rnd[o];
        end
        return p;
    endfunction

    function automatic logic [383:0] pt3(input logic [127:0] din, input logic [255:0] rnd);
        logic [383:0] p;
        for (int o = 0; o < 128; o++) begin
            p[3*o]     = rnd[o];
            p[3*o + 1] = rnd[128 + o];
            p[3*o + 2] = din[o] ^ rnd[o] ^ rnd[128 + o];
        end
        return p;
    endfunction

    function automatic logic [127:0] unshare3(input logic [383:0] p);
        logic [127:0] r;
        for (int o = 0; o < 128; o++) begin
            r[o] = p[3*o] ^ p[3*o + 1] ^ p[3*o + 2];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] din, held;
    logic [255:0] rnd_b;
    logic         seen_ov;
    int           stall;

    initial begin
        reset       = 1'b1;
        a_in_valid  = 1'b0; a_in_data = '0; a_rnd = '0;
        a_core_done = 1'b0; a_core_ct = '0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_data = '0; b_rnd = '0;
        b_core_done = 1'b0; b_core_ct = '0; b_out_ready = 1'b0;

        // ---- reset values ----
        tick(); tick();
        check("rst_in_ready",   512'(a_in_ready),   512'(1'b1));
        check("rst_core_start", 512'(a_core_start), 512'(1'b0));
        check("rst_out_valid",  512'(a_out_valid),  512'(1'b0));
        check("rst_out_data",   512'(a_out_data),   512'(128'h0));
        check("rst_core_pt",    512'(a_core_pt),    512'(256'h0));
        check("rst_err",        512'(a_err),        512'(1'b0));
        check("rst_blk_cnt",    512'(a_blk),        512'(16'h0));
        check("rst_b_in_ready", 512'(b_in_ready),   512'(1'b1));
        reset = 1'b0;

        // ---- block 1: known vector, loopback after 5 cycles ----
        din = 128'ha42757d2ace7ce858ba9b1a3215a899d;
        a_in_data = din; a_rnd = '1; a_in_valid = 1'b1;
        tick();                                   // edge 0 accept -> cycle 1
        a_in_valid = 1'b0; a_in_data = '0;
        check("b1_core_start_c1", 512'(a_core_start), 512'(1'b1));
        check("b1_in_ready_c1",   512'(a_in_ready),   512'(1'b0));
        // bit0=1: {s1,s0}={0,1}; bit1=0: {s1,s0}={1,1}
        check("b1_pt_low4",       512'(a_core_pt[3:0]), 512'(4'b1101));
        check("b1_pt_full",       512'(a_core_pt),    512'(pt2(din, '1)));
        tick();                                   // cycle 2, BUSY
        check("b1_core_start_c2", 512'(a_core_start), 512'(1'b0));
        repeat (5) tick();                        // cycle 7
        check("b1_out_valid_c7",  512'(a_out_valid),  512'(1'b0));
        check("b1_pt_stable",     512'(a_core_pt),    512'(pt2(din, '1)));
        a_core_done = 1'b1; a_core_ct = a_core_pt; a_out_ready = 1'b1;
        tick();                                   // cycle 8
        a_core_done = 1'b0; a_core_ct = '0;
        check("b1_out_valid_c8",  512'(a_out_valid),  512'(1'b1));
        check("b1_out_data",      512'(a_out_data),   512'(din));
        tick();                                   // handshake done
        a_out_ready = 1'b0;
        check("b1_out_valid_off", 512'(a_out_valid),  512'(1'b0));
        check("b1_blk_cnt",       512'(a_blk),        512'(16'd1));
        check("b1_in_ready",      512'(a_in_ready),   512'(1'b1));

        // ---- block 2: minimum latency, non-loopback result, 10-cycle OUT stall ----
        din = 128'h0123456789abcdeffedcba9876543210;
        a_in_data = din; a_rnd = {4{32'h5a5a_c3c3}}; a_in_valid = 1'b1;
        tick();                                   // cycle 1
        a_in_valid = 1'b0;
        tick();                                   // cycle 2 (first BUSY)
        a_core_done = 1'b1; a_core_ct = {128{2'b01}};
        tick();                                   // cycle 3
        a_core_done = 1'b0;
        check("b2_min_latency",   512'(a_out_valid),  512'(1'b1));
        check("b2_out_data",      512'(a_out_data),   512'({128{1'b1}}));
        for (int i = 0; i < 10; i++) begin
            a_in_valid  = i[0];
            a_in_data   = rand128();
            a_core_done = ~i[0];
            a_core_ct   = '0;
            tick();
            check("b2_stall_out_valid", 512'(a_out_valid), 512'(1'b1));
            check("b2_stall_out_data",  512'(a_out_data),  512'({128{1'b1}}));
            check("b2_stall_in_ready",  512'(a_in_ready),  512'(1'b0));
            check("b2_stall_core_pt",   512'(a_core_pt),   512'(pt2(din, {4{32'h5a5a_c3c3}})));
        end
        a_in_valid = 1'b0; a_core_done = 1'b0; a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check("b2_release_out_valid", 512'(a_out_valid), 512'(1'b0));
        check("b2_blk_cnt",           512'(a_blk),       512'(16'd2));
        check("b2_in_ready",          512'(a_in_ready),  512'(1'b1));

        // ---- block 3: done on the same edge the counter reaches TIMEOUT ----
        din = 128'hdeadbeef_00112233_44556677_8899aabb;
        a_in_data = din; a_rnd = 128'h0f0f_1234_5678_9abc_def0_1357_2468_aaaa; a_in_valid = 1'b1;
        tick();                                   // cycle 1
        a_in_valid = 1'b0;
        tick();                                   // cycle 2, count 0
        repeat (15) tick();                       // cycle 17, count 15
        a_core_done = 1'b1; a_core_ct = a_core_pt; a_out_ready = 1'b1;
        tick();
        a_core_done = 1'b0;
        check("b3_done_wins_valid", 512'(a_out_valid), 512'(1'b1));
        check("b3_done_wins_err",   512'(a_err),       512'(1'b0));
        check("b3_out_data",        512'(a_out_data),  512'(din));
        tick();
        a_out_ready = 1'b0;
        check("b3_blk_cnt",         512'(a_blk),       512'(16'd3));

        // ---- block 4: watchdog abort after 16 BUSY cycles ----
        din = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        a_in_data = din; a_rnd = rand128(); a_in_valid = 1'b1;
        tick();                                   // cycle 1
        a_in_valid = 1'b0;
        tick();                                   // cycle 2
        seen_ov = a_out_valid;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen_ov = seen_ov | a_out_valid;
        end                                       // cycle 17
        check("to_err_before",   512'(a_err),      512'(1'b0));
        check("to_in_ready_pre", 512'(a_in_ready), 512'(1'b0));
        tick();                                   // cycle 18
        check("to_err_set",      512'(a_err),      512'(1'b1));
        check("to_in_ready",     512'(a_in_ready), 512'(1'b1));
        check("to_no_out_valid", 512'(seen_ov | a_out_valid), 512'(1'b0));
        check("to_blk_cnt",      512'(a_blk),      512'(16'd3));

        // ---- block 5: still works after the abort, flag stays set ----
        din = 128'hcafef00d_0badc0de_feedface_12345678;
        a_in_data = din; a_rnd = rand128(); a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        a_core_done = 1'b1; a_core_ct = a_core_pt; a_out_ready = 1'b1;
        tick();
        a_core_done = 1'b0;
        check("b5_out_valid", 512'(a_out_valid), 512'(1'b1));
        check("b5_out_data",  512'(a_out_data),  512'(din));
        check("b5_err_stays", 512'(a_err),       512'(1'b1));
        tick();
        a_out_ready = 1'b0;
        check("b5_blk_cnt",   512'(a_blk),       512'(16'd4));
        check("b5_err_after", 512'(a_err),       512'(1'b1));

        // ---- block 6: reset mid-BUSY, late done ignored ----
        a_in_data = rand128(); a_rnd = rand128(); a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick(); tick();                           // cycle 3, BUSY
        reset = 1'b1;
        tick();
        check("mid_rst_in_ready",   512'(a_in_ready),   512'(1'b1));
        check("mid_rst_core_start", 512'(a_core_start), 512'(1'b0));
        check("mid_rst_out_valid",  512'(a_out_valid),  512'(1'b0));
        check("mid_rst_out_data",   512'(a_out_data),   512'(128'h0));
        check("mid_rst_core_pt",    512'(a_core_pt),    512'(256'h0));
        check("mid_rst_err",        512'(a_err),        512'(1'b0));
        check("mid_rst_blk_cnt",    512'(a_blk),        512'(16'h0));
        reset = 1'b0;
        a_core_done = 1'b1; a_core_ct = '1; a_out_ready = 1'b1;
        tick();
        a_core_done = 1'b0;
        tick();
        a_out_ready = 1'b0;
        check("late_done_out_valid", 512'(a_out_valid), 512'(1'b0));
        check("late_done_blk_cnt",   512'(a_blk),       512'(16'h0));
        check("late_done_in_ready",  512'(a_in_ready),  512'(1'b1));
        check("late_done_out_data",  512'(a_out_data),  512'(128'h0));

        // ---- d=3 random loopback, 1000 blocks with output stalls ----
        for (int k = 0; k < 1000; k++) begin
            din   = rand128();
            rnd_b = {rand128(), rand128()};
            check("r3_in_ready", 512'(b_in_ready), 512'(1'b1));
            b_in_data = din; b_rnd = rnd_b; b_in_valid = 1'b1;
            b_out_ready = ($urandom_range(0, 3) == 0);
            tick();                               // START
            b_in_valid = 1'b0; b_in_data = '0; b_rnd = '0;
            check("r3_core_pt",  512'(b_core_pt),           512'(pt3(din, rnd_b)));
            check("r3_share_xor", 512'(unshare3(b_core_pt)), 512'(din));
            tick();                               // first BUSY cycle
            repeat ($urandom_range(0, 3)) tick();
            b_core_done = 1'b1; b_core_ct = b_core_pt;
            tick();                               // OUT
            b_core_done = 1'b0;
            if (!b_out_ready) begin
                stall = $urandom_range(0, 3);
                repeat (stall) tick();
                b_out_ready = 1'b1;
            end
            check("r3_out_valid", 512'(b_out_valid), 512'(1'b1));
            check("r3_out_data",  512'(b_out_data),  512'(din));
            tick();                               // handshake
            b_out_ready = 1'b0;
        end
        held = 128'(b_blk);
        check("r3_blk_cnt",  512'(held),  512'(128'd1000));
        check("r3_no_error", 512'(b_err), 512'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
